// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the packed-BCD event counter.
package bcd_pkg;

    localparam int         BCD_DIGIT_W  = 4;
    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam int         BCD_MAX_BITS = 256;

    // Packed all-nines pattern for a count of 'width' bits (up to 64 digits).
    function automatic logic [BCD_MAX_BITS-1:0] bcd_all_nines(input int width);
        logic [BCD_MAX_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < BCD_MAX_BITS / BCD_DIGIT_W; i++) begin
            if (i < width / BCD_DIGIT_W) begin
                r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_MAX;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: counts 0..9 on carry-in, ripples carry-out at 9.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry_out
);

    logic [3:0] r_digit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digit <= '0;
        end else if (clear) begin
            r_digit <= '0;
        end else if (inc) begin
            r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
        end
    end

    assign digit     = r_digit;
    assign carry_out = inc && (r_digit == BCD_MAX);

endmodule

// File: rtl/bcd_event_counter.sv
// Debounced event counter with packed BCD count, overflow flag and snapshot latch.
module bcd_event_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SATURATE        = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  event_in,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  latch,
    output logic [4*DIGITS-1:0]   count,
    output logic [4*DIGITS-1:0]   snapshot,
    output logic                  snapshot_valid,
    output logic                  overflow,
    output logic                  event_pulse
);

    localparam int              W         = BCD_DIGIT_W * DIGITS;
    localparam logic [W-1:0]    ALL_NINES = W'(bcd_all_nines(W));
    localparam int              DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic [1:0]      r_sync_vld;
    logic            r_filt;
    logic            r_filt_d;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_armed;
    logic            r_pulse;
    logic            r_ovf;
    logic [W-1:0]    r_snap;
    logic            r_snap_vld;

    logic [W-1:0]    w_count;
    logic [DIGITS:0] w_carry;
    logic            w_all_nines;
    logic            w_inc_req;
    logic            w_ovf_set;

    // Pulses are armed only once a genuine low has passed the synchronizer,
    // so an input already high when reset releases never counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync_vld <= 2'b00;
            r_filt     <= 1'b0;
            r_filt_d   <= 1'b0;
            r_db_cnt   <= '0;
            r_armed    <= 1'b0;
            r_pulse    <= 1'b0;
        end else begin
            r_sync1    <= event_in;
            r_sync2    <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            if (r_sync2 != r_filt) begin
                if (r_db_cnt == DB_LAST) begin
                    r_filt   <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
            r_filt_d <= r_filt;
            if (r_sync_vld[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end
            r_pulse <= r_armed && r_filt && !r_filt_d;
        end
    end

    assign w_all_nines = (w_count == ALL_NINES);
    assign w_inc_req   = r_pulse && enable;
    assign w_carry[0]  = w_inc_req && !((SATURATE != 0) && w_all_nines);
    assign w_ovf_set   = (SATURATE != 0) ? (w_inc_req && w_all_nines) : w_carry[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .reset_n   (reset_n),
            .clear     (clear),
            .inc       (w_carry[g]),
            .digit     (w_count[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .carry_out (w_carry[g+1])
        );
    end

    // Snapshot captures the pre-update count, so it survives a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf      <= 1'b0;
            r_snap     <= '0;
            r_snap_vld <= 1'b0;
        end else begin
            if (clear) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            if (latch) begin
                r_snap <= w_count;
            end
            r_snap_vld <= latch;
        end
    end

    assign count          = w_count;
    assign snapshot       = r_snap;
    assign snapshot_valid = r_snap_vld;
    assign overflow       = r_ovf;
    assign event_pulse    = r_pulse;

endmodule

// File: tb/tb_bcd_event_counter.sv
// Bench for bcd_event_counter: 4-digit wrap instance plus 2-digit wrap/saturate instances.
module tb_bcd_event_counter;

    localparam int D = 4;

    logic        clk;
    logic        reset_n;

    logic        ev_a, en_a, clr_a, lat_a;
    logic [15:0] count_a, snap_a;
    logic        sv_a, ovf_a, pulse_a;

    logic        ev_ws, en_ws, clr_w, clr_s, lat_ws;
    logic [7:0]  count_w, snap_w, count_s, snap_s;
    logic        sv_w, ovf_w, pulse_w, sv_s, ovf_s, pulse_s;

    int          total;
    int          bad;
    int          model_val;
    int          pulse_cnt_a, pulse_cnt_w, pulse_cnt_s;
    bit          pend;
    logic [15:0] exp_q[$];

    typedef struct {
        int         presses;
        logic [7:0] exp_w;
        logic       exp_ovf_w;
        logic [7:0] exp_s;
        logic       exp_ovf_s;
    } vec_t;
    vec_t vecs[3];

    bcd_event_counter #(.DIGITS(4), .DEBOUNCE_CYCLES(D), .SATURATE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .event_in(ev_a), .enable(en_a), .clear(clr_a),
        .latch(lat_a), .count(count_a), .snapshot(snap_a), .snapshot_valid(sv_a),
        .overflow(ovf_a), .event_pulse(pulse_a)
    );

    bcd_event_counter #(.DIGITS(2), .DEBOUNCE_CYCLES(D), .SATURATE(0)) dut_w (
        .clk(clk), .reset_n(reset_n), .event_in(ev_ws), .enable(en_ws), .clear(clr_w),
        .latch(lat_ws), .count(count_w), .snapshot(snap_w), .snapshot_valid(sv_w),
        .overflow(ovf_w), .event_pulse(pulse_w)
    );

    bcd_event_counter #(.DIGITS(2), .DEBOUNCE_CYCLES(D), .SATURATE(1)) dut_s (
        .clk(clk), .reset_n(reset_n), .event_in(ev_ws), .enable(en_ws), .clear(clr_s),
        .latch(lat_ws), .count(count_s), .snapshot(snap_s), .snapshot_valid(sv_s),
        .overflow(ovf_s), .event_pulse(pulse_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Scoreboard: a pulse from dut_a pops one expected count, compared a cycle later.
    always @(negedge clk) begin
        if (!reset_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                pend = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected_pulse: got count %0h expected no pulse at %0t", count_a, $time);
                end else begin
                    check("sb_count", count_a, exp_q.pop_front());
                end
            end
            if (pulse_a) begin
                pulse_cnt_a++;
                pend = 1'b1;
            end
            if (pulse_w) pulse_cnt_w++;
            if (pulse_s) pulse_cnt_s++;
        end
    end

    // All drive tasks start and end just after a rising edge.
    task automatic press_a(input int hi, input int lo);
        if (en_a) model_val = (model_val + 1) % 10000;
        exp_q.push_back(to_bcd(model_val));
        ev_a = 1'b1;
        repeat (hi) @(posedge clk);
        #1 ev_a = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    task automatic glitch_a(input int hi);
        ev_a = 1'b1;
        repeat (hi) @(posedge clk);
        #1 ev_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic press_ws(input int hi, input int lo);
        ev_ws = 1'b1;
        repeat (hi) @(posedge clk);
        #1 ev_ws = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("sb_drain", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int lat;
        bit found;
        total = 0; bad = 0; model_val = 0;
        pulse_cnt_a = 0; pulse_cnt_w = 0; pulse_cnt_s = 0; pend = 1'b0;
        reset_n = 1'b0;
        ev_a = 1'b0; en_a = 1'b1; clr_a = 1'b0; lat_a = 1'b0;
        ev_ws = 1'b0; en_ws = 1'b1; clr_w = 1'b0; clr_s = 1'b0; lat_ws = 1'b0;

        vecs[0] = '{99, 8'h99, 1'b0, 8'h99, 1'b0};
        vecs[1] = '{1,  8'h00, 1'b1, 8'h99, 1'b1};
        vecs[2] = '{1,  8'h01, 1'b1, 8'h99, 1'b1};

        // Reset held with the event input toggling.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 ev_a = ~ev_a;
        end
        @(negedge clk);
        check("rst_count", count_a, 16'h0);
        check("rst_snapshot", snap_a, 16'h0);
        check("rst_overflow", ovf_a, 0);
        check("rst_pulse", pulse_a, 0);
        check("rst_snap_valid", sv_a, 0);
        check("rst_w_outputs", {count_w, snap_w, sv_w, ovf_w}, 0);
        check("rst_s_outputs", {count_s, snap_s, sv_s, ovf_s}, 0);

        // Release with the input already high: no pulse.
        ev_a = 1'b1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("release_high_no_pulse", pulse_cnt_a, 0);
        check("release_high_count", count_a, 16'h0);
        @(posedge clk);
        #1 ev_a = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Wrap and saturate instances from the vector table.
        for (int v = 0; v < 3; v++) begin
            for (int p = 0; p < vecs[v].presses; p++) press_ws(8, 8);
            @(negedge clk);
            check("tbl_wrap_count", count_w, vecs[v].exp_w);
            check("tbl_wrap_ovf", ovf_w, vecs[v].exp_ovf_w);
            check("tbl_sat_count", count_s, vecs[v].exp_s);
            check("tbl_sat_ovf", ovf_s, vecs[v].exp_ovf_s);
            @(posedge clk);
            #1;
        end
        check("wrap_pulses", pulse_cnt_w, 101);
        check("sat_pulses", pulse_cnt_s, 101);
        clr_w = 1'b1;
        @(posedge clk);
        #1 clr_w = 1'b0;
        @(negedge clk);
        check("wrap_clear_count", count_w, 8'h00);
        check("wrap_clear_ovf", ovf_w, 0);
        @(posedge clk);
        #1;

        // First press with latency measurement, then glitches between presses.
        model_val = (model_val + 1) % 10000;
        exp_q.push_back(to_bcd(model_val));
        ev_a = 1'b1;
        lat = 0;
        found = 1'b0;
        while (lat < 20 && !found) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (pulse_a) found = 1'b1;
        end
        check("first_pulse_latency", lat, 3 + D);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 ev_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 1; i < 19; i++) begin
            glitch_a(3);
            press_a(10, 10);
        end
        glitch_a(3);
        drain();
        @(negedge clk);
        check("debounce_count", count_a, 16'h0019);
        check("debounce_pulses", pulse_cnt_a, 19);
        @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) press_a(10, 10);
        drain();

        // Press while disabled: pulse fires, count holds.
        en_a = 1'b0;
        press_a(10, 10);
        en_a = 1'b1;
        drain();
        @(negedge clk);
        check("disabled_count", count_a, 16'h0042);
        check("disabled_pulses", pulse_cnt_a, 43);
        @(posedge clk);
        #1;

        // clear + latch + increment in the same cycle.
        model_val = 0;
        exp_q.push_back(16'h0000);
        ev_a = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (pulse_a) found = 1'b1;
        end
        check("collide_pulse_seen", found, 1);
        clr_a = 1'b1;
        lat_a = 1'b1;
        @(posedge clk);
        #1 clr_a = 1'b0;
        lat_a = 1'b0;
        @(negedge clk);
        check("collide_count", count_a, 16'h0);
        check("collide_ovf", ovf_a, 0);
        check("collide_snapshot", snap_a, 16'h0042);
        check("collide_snap_valid", sv_a, 1);
        @(negedge clk);
        check("collide_snap_valid_end", sv_a, 0);
        check("collide_snapshot_hold", snap_a, 16'h0042);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 ev_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        drain();

        // Reset two cycles into a valid press.
        press_a(10, 10);
        drain();
        ev_a = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        ev_a = 1'b0;
        exp_q.delete();
        model_val = 0;
        #1;
        check("midrst_count", count_a, 16'h0);
        check("midrst_snapshot", snap_a, 16'h0);
        check("midrst_overflow", ovf_a, 0);
        check("midrst_pulse", pulse_a, 0);
        check("midrst_snap_valid", sv_a, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        press_a(10, 10);
        drain();
        @(negedge clk);
        check("after_reset_count", count_a, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_event_counter.md
# bcd_event_counter

Parametrised successor to the team's four-digit button counter. Counts debounced rising edges of an asynchronous event input into a DIGITS-wide packed BCD register, with wrap or saturate overflow modes, a sticky overflow flag, synchronous clear and a snapshot latch for display readout. It sits between raw detector/button inputs and the digit extraction and seven-segment display path.

## Interface

- DIGITS, 4: number of BCD digits; 1 or more. Count width is 4*DIGITS.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before the filtered level changes; 1 or more, where 1 means no filtering.
- SATURATE, 0: 0 wraps all-nines to zero; 1 holds at all-nines.

Ports:

- clk  in  1  system clock (100 MHz nominal)
- reset_n  in  1  asynchronous, active-low reset
- event_in  in  1  raw asynchronous event/button level
- enable  in  1  count enable; gates increments only
- clear  in  1  synchronous clear of count and overflow
- latch  in  1  copy count into snapshot
- count  out  4*DIGITS  live BCD count; digit 0 (ones) in bits [3:0]
- snapshot  out  4*DIGITS  latched BCD count
- snapshot_valid  out  1  one-cycle pulse after a latch
- overflow  out  1  sticky; set on increment from all-nines
- event_pulse  out  1  one-cycle pulse per debounced rising edge

## Operation

- Reset (reset_n low, asynchronous): all outputs are 0, synchronizer flops are 0, the filtered level is 0 and the debounce counter is 0.
- Input path: a 2-flop synchronizer feeds the debounce filter.
  - While the synchronised value differs from the filtered level, the debounce counter increments.
  - The filtered level takes the synchronised value on the edge where DEBOUNCE_CYCLES consecutive differing samples have been seen.
  - Any matching sample resets the debounce counter to 0.
- event_pulse asserts for exactly one cycle on a filtered 0->1 transition. Filtered 1->0 transitions produce no pulse.
- Increment happens when event_pulse and enable are both high.
  - BCD ripple-carry add of 1 in a single cycle.
  - Each digit counts 0..9. Carry out occurs at 9 and the digit returns to 0.
  - Digits never hold values 10..15.
- Overflow (increment while count is all-nines):
  - SATURATE=0: count becomes 0 and overflow is set.
  - SATURATE=1: count holds at all-nines and overflow is set.
- enable low: the filter and event_pulse still operate; count is unchanged.
- clear: count and overflow go to 0 on the next edge. clear has priority over an increment in the same cycle, so that event is lost.
- latch: snapshot takes the current count output (the pre-update value of this cycle), and snapshot_valid pulses on the next cycle.
  - latch together with clear: snapshot gets the pre-clear value.
  - latch together with an increment: snapshot gets the pre-increment value.
- snapshot is not affected by clear; only reset and latch change it.

## Timing

- event_in rising and stable before edge 0: event_pulse is high in the cycle after edge 2+DEBOUNCE_CYCLES. count shows the new value after edge 3+DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES synchronised samples are ignored.
- Minimum counted event: high and low each last at least DEBOUNCE_CYCLES cycles. At most one count per 2*DEBOUNCE_CYCLES cycles.
- latch -> snapshot and snapshot_valid: 1 cycle. clear -> count=0: 1 cycle.
- Reset asserted mid-debounce or mid-operation: everything returns to reset values immediately. No pulse is generated on release, even if event_in is still high, until a new filtered 0->1 transition completes.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure

- Package bcd_pkg holds BCD_DIGIT_W = 4, BCD_MAX = 4'd9, and function bcd_all_nines(width) returning the packed all-nines constant.
- Sub-module bcd_digit: one 4-bit BCD digit.
  - Inputs: clk, reset_n, clear, inc (carry-in).
  - Outputs: digit, carry_out (inc && digit==9).
  - Instantiated DIGITS times in a generate loop. In SATURATE mode the top level suppresses inc when the count is all-nines.
- The synchronizer, debounce, snapshot and overflow logic stay inline in the top level.

## Test plan

- Reset: hold reset_n low with event_in toggling -> count=0, snapshot=0, overflow=0, event_pulse=0, snapshot_valid=0. After release with event_in already high -> no pulse.
- Debounce (DIGITS=4, D=4): 19 clean presses with 100 ns high/low, plus 3-cycle glitches in between -> count=16'h0019, exactly 19 event_pulse cycles. Check the 2+D latency for the first pulse.
- Wrap (DIGITS=2, SATURATE=0): 99 presses -> count=8'h99 and overflow=0; 100th press -> count=8'h00 and overflow=1; 101st press -> count=8'h01 and overflow still 1.
- Saturate (DIGITS=2, SATURATE=1): 100 presses -> count=8'h99 and overflow=1; a further press -> count unchanged.
- enable/clear collisions: enable=0 during a press -> event_pulse fires, count stays 16'h0042. With count=16'h0042, assert clear, latch and a press pulse in the same cycle -> count=0, overflow=0, snapshot=16'h0042, snapshot_valid one cycle later.
- Reset mid-debounce: assert reset_n low 2 cycles into a valid press -> all zeros. Release with event_in low, then one clean press -> count=16'h0001.
